// File: rtl/universal_register_pkg.sv
// Shared definitions for the universal register: mode type and mode encodings.
// Nothing here depends on the register width.
package universal_register_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'd0;
  localparam mode_t MODE_LOAD = 3'd1;
  localparam mode_t MODE_SHL  = 3'd2;
  localparam mode_t MODE_SHR  = 3'd3;
  localparam mode_t MODE_ROTL = 3'd4;
  localparam mode_t MODE_ROTR = 3'd5;
  localparam mode_t MODE_INC  = 3'd6;
  localparam mode_t MODE_DEC  = 3'd7;

endpackage

// File: rtl/ureg_cell.sv
// One bit slice of the universal register: mode mux feeding an async-clear flop.
// Neighbour and adder bits are routed in by the top, so the slice is width-agnostic.
module ureg_cell
  import universal_register_pkg::*;
(
  input  logic  clk,
  input  logic  clr,
  input  logic  en,
  input  mode_t mode,
  input  logic  d,
  input  logic  left_in,
  input  logic  right_in,
  input  logic  sum_in,
  output logic  q
);

  logic next_s;

  // Select this bit's next value from the current command
  always_comb begin
    next_s = q;
    if (en) begin
      case (mode)
        MODE_HOLD: next_s = q;
        MODE_LOAD: next_s = d;
        MODE_SHL:  next_s = left_in;
        MODE_SHR:  next_s = right_in;
        MODE_ROTL: next_s = left_in;
        MODE_ROTR: next_s = right_in;
        MODE_INC:  next_s = sum_in;
        MODE_DEC:  next_s = sum_in;
        default:   next_s = q;
      endcase
    end else begin
      next_s = q;
    end
  end

  // Storage flop, cleared asynchronously
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= 1'b0;
    end else begin
      q <= next_s;
    end
  end

endmodule

// File: rtl/universal_register.sv
// Parametrised universal register: hold/load/shift/rotate/inc/dec with wrap flag.
// Built from WIDTH ureg_cell slices plus a shared inc/dec adder.
module universal_register
  import universal_register_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sil,
  input  logic             sir,
  output logic [WIDTH-1:0] Q,
  output logic             so_l,
  output logic             so_r,
  output logic             co,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] left_s;
  logic [WIDTH-1:0] right_s;
  logic             wrap_s;

  // Shared adder plus end-of-chain injection for shifts versus rotates
  always_comb begin
    sum_s   = Q + ONE_W;
    left_s  = {Q[WIDTH-2:0], sil};
    right_s = {sir, Q[WIDTH-1:1]};
    wrap_s  = 1'b0;
    if (mode == MODE_DEC) begin
      sum_s  = Q - ONE_W;
      wrap_s = (Q == ZERO_W);
    end else if (mode == MODE_INC) begin
      wrap_s = (Q == ONES_W);
    end else begin
      wrap_s = 1'b0;
    end
    if (mode == MODE_ROTL) begin
      left_s[0] = Q[WIDTH-1];
    end else begin
      left_s[0] = sil;
    end
    if (mode == MODE_ROTR) begin
      right_s[WIDTH-1] = Q[0];
    end else begin
      right_s[WIDTH-1] = sir;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ureg_cell u_cell (
      .clk      (clk),
      .clr      (clr),
      .en       (en),
      .mode     (mode),
      .d        (D[i]),
      .left_in  (left_s[i]),
      .right_in (right_s[i]),
      .sum_in   (sum_s[i]),
      .q        (Q[i])
    );
  end

  // Wrap flag: set only by a wrapping inc/dec, cleared by any other enabled edge
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      co <= 1'b0;
    end else if (en) begin
      co <= wrap_s;
    end else begin
      co <= co;
    end
  end

  assign so_l = Q[WIDTH-1];
  assign so_r = Q[0];
  assign zero = (Q == ZERO_W);

endmodule

// File: tb/tb_universal_register.sv
// Self-checking bench: directed vector table at WIDTH=4, hand-written reset
// sequences, and a model-checked random run on WIDTH=4, 2 and 16 instances.
module tb_universal_register;

  logic        clk;
  logic        clr;
  logic        en;
  logic [2:0]  mode;
  logic [15:0] d;
  logic        sil;
  logic        sir;

  logic [3:0]  q4;
  logic        sol4, sor4, co4, z4;
  logic [1:0]  q2;
  logic        sol2, sor2, co2, z2;
  logic [15:0] q16;
  logic        sol16, sor16, co16, z16;

  int checks = 0;
  int errors = 0;

  universal_register #(.WIDTH(4)) dut4 (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .D(d[3:0]), .sil(sil), .sir(sir),
    .Q(q4), .so_l(sol4), .so_r(sor4), .co(co4), .zero(z4));
  universal_register #(.WIDTH(2)) dut2 (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .D(d[1:0]), .sil(sil), .sir(sir),
    .Q(q2), .so_l(sol2), .so_r(sor2), .co(co2), .zero(z2));
  universal_register #(.WIDTH(16)) dut16 (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .D(d), .sil(sil), .sir(sir),
    .Q(q16), .so_l(sol16), .so_r(sor16), .co(co16), .zero(z16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic [3:0] d;
    logic       sil;
    logic       sir;
    logic [3:0] eq;
    logic       eco;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // packs {Q, co, zero, so_l, so_r} of the WIDTH=4 instance
  function automatic logic [31:0] obs4();
    return {24'd0, q4, co4, z4, sol4, sor4};
  endfunction

  function automatic logic [31:0] exp4(input logic [3:0] q, input logic c);
    return {24'd0, q, c, (q == 4'd0), q[3], q[0]};
  endfunction

  // reference next state {co, q} for a register of width w
  function automatic logic [16:0] model(input logic [15:0] q, input int w, input logic e,
                                        input logic [2:0] m, input logic [15:0] dd,
                                        input logic sl, input logic sr, input logic c);
    logic [15:0] msk;
    logic [15:0] nq;
    logic        nc;
    msk = 16'hFFFF >> (16 - w);
    nq  = q;
    nc  = c;
    if (e) begin
      nc = 1'b0;
      case (m)
        3'd1: nq = dd & msk;
        3'd2: nq = ((q << 1) | 16'(sl)) & msk;
        3'd3: nq = (q >> 1) | (16'(sr) << (w - 1));
        3'd4: nq = ((q << 1) | 16'(q[w-1])) & msk;
        3'd5: nq = (q >> 1) | (16'(q[0]) << (w - 1));
        3'd6: begin nq = (q + 16'd1) & msk; nc = (q == msk); end
        3'd7: begin nq = (q - 16'd1) & msk; nc = (q == 16'd0); end
        default: nq = q;
      endcase
    end
    return {nc, nq};
  endfunction

  logic [15:0] mq[3];
  logic        mco[3];
  int          wd[3];
  logic [16:0] nx;
  logic [15:0] aq;
  logic [3:0]  af;
  logic [15:0] msk;

  initial begin
    wd[0] = 4; wd[1] = 2; wd[2] = 16;
    //          en    mode  d      sil   sir   Q      co
    tbl[0]  = '{1'b1, 3'd1, 4'hA, 1'b0, 1'b0, 4'hA, 1'b0};
    tbl[1]  = '{1'b0, 3'd6, 4'h0, 1'b0, 1'b0, 4'hA, 1'b0};
    tbl[2]  = '{1'b0, 3'd6, 4'h5, 1'b1, 1'b1, 4'hA, 1'b0};
    tbl[3]  = '{1'b0, 3'd6, 4'h0, 1'b0, 1'b0, 4'hA, 1'b0};
    tbl[4]  = '{1'b1, 3'd1, 4'h9, 1'b0, 1'b0, 4'h9, 1'b0};
    tbl[5]  = '{1'b1, 3'd2, 4'h0, 1'b1, 1'b0, 4'h3, 1'b0};
    tbl[6]  = '{1'b1, 3'd3, 4'h0, 1'b0, 1'b1, 4'h9, 1'b0};
    tbl[7]  = '{1'b1, 3'd4, 4'h0, 1'b0, 1'b0, 4'h3, 1'b0};
    tbl[8]  = '{1'b1, 3'd5, 4'h0, 1'b0, 1'b0, 4'h9, 1'b0};
    tbl[9]  = '{1'b1, 3'd2, 4'h0, 1'b0, 1'b1, 4'h2, 1'b0};
    tbl[10] = '{1'b1, 3'd3, 4'h0, 1'b1, 1'b0, 4'h1, 1'b0};
    tbl[11] = '{1'b1, 3'd1, 4'hE, 1'b0, 1'b0, 4'hE, 1'b0};
    tbl[12] = '{1'b1, 3'd6, 4'h0, 1'b0, 1'b0, 4'hF, 1'b0};
    tbl[13] = '{1'b1, 3'd6, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1};
    tbl[14] = '{1'b1, 3'd6, 4'h0, 1'b0, 1'b0, 4'h1, 1'b0};
    tbl[15] = '{1'b1, 3'd7, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0};
    tbl[16] = '{1'b1, 3'd7, 4'h0, 1'b0, 1'b0, 4'hF, 1'b1};
    tbl[17] = '{1'b0, 3'd7, 4'h0, 1'b0, 1'b0, 4'hF, 1'b1};
    tbl[18] = '{1'b1, 3'd0, 4'h0, 1'b0, 1'b0, 4'hF, 1'b0};
    tbl[19] = '{1'b1, 3'd4, 4'h0, 1'b0, 1'b0, 4'hF, 1'b0};

    clr = 1'b1; en = 1'b0; mode = 3'd0; d = 16'd0; sil = 1'b0; sir = 1'b0;
    #1;
    chk("reset_state", obs4(), exp4(4'h0, 1'b0));
    @(posedge clk); #2;
    clr = 1'b0;

    // directed table
    for (int i = 0; i < 20; i++) begin
      en = tbl[i].en; mode = tbl[i].mode; d = {12'd0, tbl[i].d};
      sil = tbl[i].sil; sir = tbl[i].sir;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), obs4(), exp4(tbl[i].eq, tbl[i].eco));
    end

    // async clear with no clock edge, then held clear ignores LOAD
    en = 1'b1; mode = 3'd1; d = 16'h000B;
    @(posedge clk); #1;
    chk("load_1011", obs4(), exp4(4'hB, 1'b0));
    #1 clr = 1'b1;
    #1 chk("async_clr", obs4(), exp4(4'h0, 1'b0));
    d = 16'h000F;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk($sformatf("clr_hold%0d", i), obs4(), exp4(4'h0, 1'b0));
    end

    // INC run interrupted by clear between edges, no resume
    clr = 1'b0; mode = 3'd6;
    repeat (3) @(posedge clk);
    #1 chk("inc_run", obs4(), exp4(4'h3, 1'b0));
    #1 clr = 1'b1;
    #1 chk("mid_clr", obs4(), exp4(4'h0, 1'b0));
    #1 clr = 1'b0;
    @(posedge clk); #1;
    chk("after_clr_inc", obs4(), exp4(4'h1, 1'b0));

    // random regression on all three widths
    clr = 1'b1; en = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin mq[k] = 16'd0; mco[k] = 1'b0; end
    for (int n = 0; n < 2000; n++) begin
      #1;
      clr  = ($urandom_range(0, 31) == 0);
      en   = ($urandom_range(0, 3) != 0);
      mode = 3'($urandom_range(0, 7));
      d    = 16'($urandom);
      sil  = 1'($urandom);
      sir  = 1'($urandom);
      if (clr) begin
        for (int k = 0; k < 3; k++) begin mq[k] = 16'd0; mco[k] = 1'b0; end
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!clr) begin
          nx = model(mq[k], wd[k], en, mode, d, sil, sir, mco[k]);
          mq[k] = nx[15:0]; mco[k] = nx[16];
        end
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        case (k)
          0: begin aq = {12'd0, q4};  af = {co4, z4, sol4, sor4}; end
          1: begin aq = {14'd0, q2};  af = {co2, z2, sol2, sor2}; end
          default: begin aq = q16; af = {co16, z16, sol16, sor16}; end
        endcase
        msk = 16'hFFFF >> (16 - wd[k]);
        chk($sformatf("rand_w%0d_c%0d", wd[k], n), {12'd0, aq, af},
            {12'd0, mq[k] & msk, mco[k], (mq[k] == 16'd0), mq[k][wd[k]-1], mq[k][0]});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
